alu_instr_stim_gen: RTL

- Synthesizable instruction-stream source feeding the sodor5 verification top's instruction input (core imem response data and the ISA model in parallel).
- Replaces ad-hoc per-cycle random generation with a seeded, reproducible LFSR generator.
- Emits constrained RV32I OP-IMM instructions with a valid/ready handshake.
- Issues NOPs during warm-up and after the programmed instruction budget is spent.

---
 rtl/stim_pkg.sv | 22 ++
 rtl/stim_lfsr32.sv | 24 ++
 rtl/alu_instr_stim_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/stim_pkg.sv
// Shared opcodes, masks, FSM state type and the LFSR step function for the
// RV32I instruction stimulus generator.
package stim_pkg;

  localparam logic [6:0]  OPC_OP_IMM        = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD          = 7'b0000011;
  localparam logic [31:0] LFSR_MASK         = 32'h80200003;
  localparam logic [11:0] SHIFT_IMM_MASK_SR = 12'h41F;
  localparam logic [11:0] SHIFT_IMM_MASK_SL = 12'h01F;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    DONE   = 2'd2
  } stim_state_e;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit Galois LFSR; reset loads the seed (zero seed replaced by 1), step
// advances one position.
module stim_lfsr32
  import stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h000003FA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  output logic [31:0] state
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'h00000001 : SEED;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED_EFF;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/alu_instr_stim_gen.sv
// Seeded RV32I OP-IMM instruction source with valid/ready handshake, NOP
// warm-up and instruction budget. Define STIM_LOAD_MIX_EN to mix in LB/LBU.
module alu_instr_stim_gen
  import stim_pkg::*;
#(
  parameter logic [31:0] SEED          = 32'h000003FA,
  parameter int unsigned WARMUP_CYCLES = 3,
  parameter int unsigned NUM_INSTRS    = 100,
  parameter logic [31:0] NOP_WORD      = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        is_random,
  output logic [31:0] issued_count,
  output logic        done
);

  localparam logic [31:0] WARM_LIM   = WARMUP_CYCLES;
  localparam logic [31:0] INSTR_LIM  = NUM_INSTRS;

  stim_state_e state_q;
  logic        vld_p0;
  logic [31:0] warm_cnt_q;
  logic [31:0] warm_cnt_nxt;
  logic [31:0] lfsr_s;
  logic [31:0] rand_word;
  logic [11:0] imm;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic        xfer;
  logic        unused_lfsr_bits;

  assign xfer      = vld_p0 && out_ready;
  assign out_valid = vld_p0;
  assign is_random = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign instr     = is_random ? rand_word : NOP_WORD;

  // Counter saturates at the limit so a late enable still finds a match.
  assign warm_cnt_nxt = warm_cnt_q +
                        ((xfer && (warm_cnt_q != WARM_LIM)) ? 32'd1 : 32'd0);

  stim_lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (is_random && xfer),
    .state  (lfsr_s)
  );

  // Control: handshake valid, phase FSM, counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WARMUP;
      vld_p0       <= 1'b0;
      warm_cnt_q   <= 32'd0;
      issued_count <= 32'd0;
    end else begin
      vld_p0 <= 1'b1;
      case (state_q)
        WARMUP: begin
          warm_cnt_q <= warm_cnt_nxt;
          if (enable && (warm_cnt_nxt == WARM_LIM)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            issued_count <= issued_count + 32'd1;
            if ((INSTR_LIM != 32'd0) && (issued_count + 32'd1 == INSTR_LIM)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= WARMUP;
        end
      endcase
    end
  end

  // Decode: LFSR state to instruction word, combinational.
  always_comb begin
    imm    = lfsr_s[31:20];
    funct3 = lfsr_s[14:12];
    opcode = OPC_OP_IMM;
    if (funct3 == 3'd5) begin
      imm = imm & SHIFT_IMM_MASK_SR;
    end else if (funct3 == 3'd1) begin
      imm = imm & SHIFT_IMM_MASK_SL;
    end
`ifdef STIM_LOAD_MIX_EN
    if (lfsr_s[1:0] == 2'b00) begin
      opcode = OPC_LOAD;
      funct3 = lfsr_s[14:12] & 3'b100;
      imm    = lfsr_s[31:20];
    end
`endif
    rand_word = {imm, lfsr_s[19:15], funct3, lfsr_s[11:7], opcode};
  end

  assign unused_lfsr_bits = ^lfsr_s[6:0];

endmodule
